// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package sram_arbiter_pkg;

   localparam int SRAM_AW = 18;
   localparam int SRAM_DW = 16;

   localparam int ARB_VGA  = 0;
   localparam int ARB_UART = 1;
   localparam int ARB_M1   = 2;

   typedef enum logic [1:0] {
      S_ARB_IDLE    = 2'd0,
      S_ARB_GRANT   = 2'd1,
      S_ARB_RELEASE = 2'd2
   } arb_state_type;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle of the SRAM arbiter: per-requester request/data plus the arbitrated SRAM bus.
interface sram_arbiter_if #(
   parameter int NUM_REQ = 3
) ();
   import sram_arbiter_pkg::*;

   logic [NUM_REQ-1:0]              req;
   logic [NUM_REQ-1:0][SRAM_AW-1:0] req_address;
   logic [NUM_REQ-1:0][SRAM_DW-1:0] req_write_data;
   logic [NUM_REQ-1:0]              req_we_n;
   logic [NUM_REQ-1:0]              gnt;
   logic [NUM_REQ-1:0]              rvalid;
   logic [SRAM_AW-1:0]              SRAM_address;
   logic [SRAM_DW-1:0]              SRAM_write_data;
   logic                            SRAM_we_n;

   modport master (
      output req, req_address, req_write_data, req_we_n,
      input  gnt, rvalid, SRAM_address, SRAM_write_data, SRAM_we_n
   );

   modport slave (
      input  req, req_address, req_write_data, req_we_n,
      output gnt, rvalid, SRAM_address, SRAM_write_data, SRAM_we_n
   );

endinterface

// File: rtl/sram_arbiter_arb_select.sv
// Combinational owner selection: lowest index wins; with SRAM_ARB_RR_EN, UART/M1 alternate.
module arb_select
   import sram_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] req_i,
`ifdef SRAM_ARB_RR_EN
   input  logic [1:0]         last_served_i,
`endif
   output logic [NUM_REQ-1:0] sel_o
);

   logic [NUM_REQ-1:0] pri_req;

   always_comb begin
      pri_req = req_i;
`ifdef SRAM_ARB_RR_EN
      // When UART and M1 contend without VGA, hide whichever was served last.
      if (!req_i[ARB_VGA] && req_i[ARB_UART] && req_i[ARB_M1]) begin
         if (last_served_i == 2'd1)
            pri_req[ARB_UART] = 1'b0;
         else
            pri_req[ARB_M1] = 1'b0;
      end
`endif
      sel_o = pri_req & (~pri_req + NUM_REQ'(1));
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shared SRAM port arbiter: priority VGA > UART > M1, burst limiting and a read-valid pipeline.
// Build with SRAM_ARB_RR_EN defined to round-robin between UART and M1.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = 3,
   parameter int READ_LATENCY = 2,
   parameter int MAX_BURST    = 64
) (
   input logic           CLOCK_50_I,
   input logic           resetn,
   sram_arbiter_if.slave bus
);

   localparam logic [1:0] ST_IDLE    = 2'(S_ARB_IDLE);
   localparam logic [1:0] ST_GRANT   = 2'(S_ARB_GRANT);
   localparam logic [1:0] ST_RELEASE = 2'(S_ARB_RELEASE);

   logic [1:0]                              state_q, state_d;
   logic [NUM_REQ-1:0]                      owner_q, owner_d;
   logic [6:0]                              burst_q, burst_d;
   logic [READ_LATENCY-1:0][NUM_REQ-1:0]    rd_pipe_q;
`ifdef SRAM_ARB_RR_EN
   logic [1:0]                              last_q, last_d;
`endif

   logic [NUM_REQ-1:0] sel, gnt, issue;
   logic               owner_req, others_pending, at_limit;
   logic [SRAM_AW-1:0] sram_addr;
   logic [SRAM_DW-1:0] sram_wdata;
   logic               sram_we_n;

   arb_select #(.NUM_REQ(NUM_REQ)) u_sel (
      .req_i         (bus.req),
`ifdef SRAM_ARB_RR_EN
      .last_served_i (last_q),
`endif
      .sel_o         (sel)
   );

   assign gnt            = (state_q == ST_GRANT) ? owner_q : '0;
   assign owner_req      = |(owner_q & bus.req);
   assign others_pending = |(bus.req & ~owner_q);
   assign at_limit       = (burst_q >= 7'(MAX_BURST - 1));

   // A write is only let through while the owner still holds its request.
   always_comb begin
      sram_addr  = '0;
      sram_wdata = '0;
      sram_we_n  = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sram_addr  = bus.req_address[i];
            sram_wdata = bus.req_write_data[i];
            sram_we_n  = bus.req_we_n[i] | ~bus.req[i];
         end
      end
   end

   assign issue = sram_we_n ? (gnt & bus.req) : '0;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      burst_d = burst_q;
`ifdef SRAM_ARB_RR_EN
      last_d  = last_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|bus.req) begin
               state_d = ST_GRANT;
               owner_d = sel;
               burst_d = '0;
`ifdef SRAM_ARB_RR_EN
               if (sel[ARB_UART])
                  last_d = 2'd1;
               else if (sel[ARB_M1])
                  last_d = 2'd2;
`endif
            end
         end
         ST_GRANT: begin
            if (burst_q != 7'h7F)
               burst_d = burst_q + 7'd1;
            if (!owner_req || (at_limit && others_pending))
               state_d = ST_RELEASE;
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         owner_q   <= '0;
         burst_q   <= '0;
         rd_pipe_q <= '0;
`ifdef SRAM_ARB_RR_EN
         last_q    <= 2'd2;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         burst_q      <= burst_d;
         rd_pipe_q[0] <= issue;
         for (int k = 1; k < READ_LATENCY; k++)
            rd_pipe_q[k] <= rd_pipe_q[k-1];
`ifdef SRAM_ARB_RR_EN
         last_q       <= last_d;
`endif
      end
   end

   assign bus.gnt             = gnt;
   assign bus.rvalid          = rd_pipe_q[READ_LATENCY-1];
   assign bus.SRAM_address    = sram_addr;
   assign bus.SRAM_write_data = sram_wdata;
   assign bus.SRAM_we_n       = sram_we_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: priority, release, burst limit, read latency, reset.
module tb_sram_arbiter;
   import sram_arbiter_pkg::*;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cnt;
   logic [2:0] seen, exp_g;

   sram_arbiter_if #(.NUM_REQ(3)) bus ();

   sram_arbiter #(.NUM_REQ(3), .READ_LATENCY(2), .MAX_BURST(64)) dut (
      .CLOCK_50_I (clk),
      .resetn     (resetn),
      .bus        (bus)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      bus.req            = '0;
      bus.req_we_n       = '1;
      bus.req_address[0] = 18'h00AAA;
      bus.req_address[1] = 18'h01111;
      bus.req_address[2] = 18'h02222;
      bus.req_write_data = {16'hC2C2, 16'hB1B1, 16'hA0A0};

      // reset state
      tick(); tick(); #1;
      chk("rst_gnt",    32'(bus.gnt), 32'h0);
      chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
      chk("rst_we_n",   32'(bus.SRAM_we_n), 32'h1);
      chk("rst_addr",   32'(bus.SRAM_address), 32'h0);
      chk("rst_state",  32'(dut.state_q), 32'(S_ARB_IDLE));
      resetn = 1'b1;

      // UART and M1 together: UART wins, bus mirrors UART
      tick(); bus.req = 3'b110; #1;
      chk("a_idle_gnt", 32'(bus.gnt), 32'h0);
      tick(); #1;
      chk("a_gnt",    32'(bus.gnt), 32'h2);
      chk("a_addr",   32'(bus.SRAM_address), 32'h01111);
      chk("a_wdata",  32'(bus.SRAM_write_data), 32'hB1B1);
      chk("a_we_n",   32'(bus.SRAM_we_n), 32'h1);
      tick(); bus.req = 3'b000; #1;
      tick(); #1;
      chk("a_rel_gnt",   32'(bus.gnt), 32'h0);
      chk("a_rel_state", 32'(dut.state_q), 32'(S_ARB_RELEASE));
      chk("a_rel_we_n",  32'(bus.SRAM_we_n), 32'h1);
      chk("a_rvalid",    32'(bus.rvalid), 32'h2);
      tick(); #1;
      chk("a_idle_state", 32'(dut.state_q), 32'(S_ARB_IDLE));

      // M1 read / write / read, then release
      tick(); bus.req = 3'b100; bus.req_address[2] = 18'h02000; #1;
      tick(); #1;
      chk("b_gnt",  32'(bus.gnt), 32'h4);
      chk("b_addr", 32'(bus.SRAM_address), 32'h02000);
      chk("b_we_n", 32'(bus.SRAM_we_n), 32'h1);
      tick(); bus.req_address[2] = 18'h02001; bus.req_we_n[2] = 1'b0; #1;
      chk("b_wr_we_n",  32'(bus.SRAM_we_n), 32'h0);
      chk("b_wr_data",  32'(bus.SRAM_write_data), 32'hC2C2);
      chk("b_wr_addr",  32'(bus.SRAM_address), 32'h02001);
      chk("b_rvalid_0", 32'(bus.rvalid), 32'h0);
      tick(); bus.req_address[2] = 18'h02002; bus.req_we_n[2] = 1'b1; #1;
      chk("b_rvalid_1", 32'(bus.rvalid), 32'h4);
      chk("b_addr3",    32'(bus.SRAM_address), 32'h02002);
      tick(); bus.req = 3'b000; #1;
      chk("b_rvalid_wr", 32'(bus.rvalid), 32'h0);
      tick(); #1;
      chk("b_rel_gnt",  32'(bus.gnt), 32'h0);
      chk("b_rel_we_n", 32'(bus.SRAM_we_n), 32'h1);
      chk("b_rvalid_2", 32'(bus.rvalid), 32'h4);
      tick(); #1;
      chk("b_idle_gnt",   32'(bus.gnt), 32'h0);
      chk("b_idle_state", 32'(dut.state_q), 32'(S_ARB_IDLE));

      // UART burst preempted by VGA after 64 granted cycles
      tick(); bus.req = 3'b010; #1;
      cnt = 0;
      for (int i = 1; i <= 64; i++) begin
         tick();
         if (i == 2) bus.req = 3'b011;
         #1;
         if (bus.gnt == 3'b010) cnt++;
      end
      chk("c_burst_len", 32'(cnt), 32'd64);
      tick(); #1;
      chk("c_preempt_gnt",   32'(bus.gnt), 32'h0);
      chk("c_preempt_state", 32'(dut.state_q), 32'(S_ARB_RELEASE));
      tick(); #1;
      chk("c_idle_gnt", 32'(bus.gnt), 32'h0);
      tick(); #1;
      chk("c_vga_gnt",  32'(bus.gnt), 32'h1);
      chk("c_vga_addr", 32'(bus.SRAM_address), 32'h00AAA);
      tick(); bus.req = 3'b000;
      repeat (3) tick();
      #1;
      chk("c_idle_state", 32'(dut.state_q), 32'(S_ARB_IDLE));

      // UART alone for 100 cycles: never preempted
      tick(); bus.req = 3'b010; #1;
      cnt = 0;
      repeat (100) begin
         tick(); #1;
         if (bus.gnt == 3'b010) cnt++;
      end
      chk("d_hold_len", 32'(cnt), 32'd100);
      tick(); bus.req = 3'b000;
      repeat (3) tick();

      // fresh reset, then UART and M1 both re-requesting short bursts
      #1; resetn = 1'b0; #1;
      chk("e_rst_state", 32'(dut.state_q), 32'(S_ARB_IDLE));
      resetn = 1'b1;
      bus.req = 3'b110;
      for (int b = 0; b < 4; b++) begin
         seen = '0;
         for (int w = 0; w < 10 && seen == 3'b000; w++) begin
            tick(); #1;
            seen = bus.gnt;
         end
`ifdef SRAM_ARB_RR_EN
         exp_g = (b % 2 == 1) ? 3'b100 : 3'b010;
`else
         exp_g = 3'b010;
`endif
         chk("e_grant", 32'(seen), 32'(exp_g));
         tick(); #1;
         tick(); bus.req = bus.req & ~seen; #1;
         tick(); bus.req = bus.req | seen; #1;
         chk("e_release", 32'(bus.gnt), 32'h0);
         tick(); #1;
      end
      bus.req = 3'b000;
      repeat (2) tick();

      // reset in the middle of an M1 read burst
      tick(); bus.req = 3'b100; bus.req_we_n = 3'b111; #1;
      tick(); #1;
      chk("f_gnt_1", 32'(bus.gnt), 32'h4);
      tick(); #1;
      chk("f_gnt_2", 32'(bus.gnt), 32'h4);
      #1; resetn = 1'b0; #1;
      chk("f_rst_gnt",    32'(bus.gnt), 32'h0);
      chk("f_rst_rvalid", 32'(bus.rvalid), 32'h0);
      chk("f_rst_we_n",   32'(bus.SRAM_we_n), 32'h1);
      chk("f_rst_state",  32'(dut.state_q), 32'(S_ARB_IDLE));
      bus.req = 3'b000;
      #1; resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         chk("f_post_rvalid", 32'(bus.rvalid), 32'h0);
         chk("f_post_gnt",    32'(bus.gnt), 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter: NUM_REQ, 3, number of requesters; index 0 VGA, 1 UART, 2 M1.
REQ-002 SHALL have parameter: READ_LATENCY, 2, cycles from address issue to valid SRAM_read_data.
REQ-003 SHALL have parameter: MAX_BURST, 64, maximum consecutive granted cycles while another request is pending.
REQ-004 SHALL have port: CLOCK_50_I  input  1  clock; all logic is on the rising edge.
REQ-005 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: req  input  NUM_REQ  per-requester access request, level-held for the whole burst.
REQ-007 SHALL have port: req_address  input  NUM_REQ x 18  per-requester SRAM address.
REQ-008 SHALL have port: req_write_data  input  NUM_REQ x 16  per-requester write data.
REQ-009 SHALL have port: req_we_n  input  NUM_REQ  per-requester write enable, active-low.
REQ-010 SHALL have port: gnt  output  NUM_REQ  one-hot grant (all zero when idle).
REQ-011 SHALL have port: rvalid  output  NUM_REQ  read data valid for the issuing requester.
REQ-012 SHALL have port: SRAM_address  output  18  to SRAM_Controller.
REQ-013 SHALL have port: SRAM_write_data  output  16  to SRAM_Controller.
REQ-014 SHALL have port: SRAM_we_n  output  1  to SRAM_Controller.

Function
REQ-015 SHALL implement the FSM S_ARB_IDLE -> S_ARB_GRANT -> S_ARB_RELEASE -> S_ARB_IDLE.
REQ-016 In S_ARB_IDLE, any req high SHALL register the selected owner, assert its gnt on the next cycle, and enter S_ARB_GRANT.
REQ-017 Arbitration SHALL use fixed priority; VGA (index 0) is always highest, and UART beats M1 unless SRAM_ARB_RR_EN is defined.
REQ-018 In S_ARB_GRANT, SRAM_address, SRAM_write_data and SRAM_we_n SHALL combinationally mirror the owner's inputs while gnt is high.
REQ-019 When not granted, SRAM_we_n SHALL be 1, SRAM_address 0 and SRAM_write_data 0.
REQ-020 Deassertion of the owner's req SHALL drop gnt on the next edge and enter S_ARB_RELEASE for exactly one dead cycle, with SRAM_we_n=1.
REQ-021 Burst counter: 7-bit, cleared on grant, +1 per S_ARB_GRANT cycle, saturating.
REQ-022 When the burst counter reaches MAX_BURST-1 while another req is high, gnt SHALL be forcibly dropped (-> S_ARB_RELEASE).
REQ-023 When the burst counter reaches MAX_BURST-1 and no other req is high, the grant SHALL continue.
REQ-024 After a forced release, the preempted requester SHALL re-arbitrate normally while its req stays high.
REQ-025 Each granted cycle with SRAM_we_n=1 SHALL push the owner index into a READ_LATENCY-deep pipeline.
REQ-026 rvalid[i] SHALL assert exactly READ_LATENCY cycles after issue, including after gnt has dropped.
REQ-027 A req that rises in the same cycle the owner releases SHALL be arbitrated only in S_ARB_IDLE, never in S_ARB_RELEASE.
REQ-028 A requester SHALL ignore gnt for any cycle in which its own req is low; the arbiter SHALL never grant a requester whose req is low.

Reset
REQ-029 On resetn low, the arbiter SHALL asynchronously enter S_ARB_IDLE.
REQ-030 On resetn low, gnt=0, rvalid=0, the read pipeline and burst counter SHALL be cleared, and SRAM_we_n=1.
REQ-031 Reset mid-burst SHALL discard outstanding reads; no rvalid SHALL be generated for them.

Configuration
REQ-032 Macro SRAM_ARB_RR_EN defined: UART and M1 SHALL alternate by round-robin; the last-served flag updates on each grant to 1 or 2, and VGA priority is unchanged.
REQ-033 Macro SRAM_ARB_RR_EN undefined: strict priority 0 > 1 > 2 SHALL apply, with no round-robin state synthesized.

Structure
REQ-034 The shared package SHALL hold the arb_state_type enum, requester index constants (ARB_VGA, ARB_UART, ARB_M1) and the 18/16-bit SRAM width constants.
REQ-035 The priority/round-robin selector SHALL be one sub-module, arb_select: combinational, taking req and last_served and producing a one-hot selection.

Verification
REQ-036 Bench: req=3'b110 in IDLE -> gnt=3'b010 (strict priority) one cycle later, and SRAM_address equals req_address[1].
REQ-037 Bench: M1 owns the bus with reads and drops req -> one cycle with gnt=0 and SRAM_we_n=1; rvalid[2] is asserted 2 cycles after each read address.
REQ-038 Bench: UART holds req for 100 cycles with VGA req high -> UART gnt drops after 64 granted cycles and VGA is granted 2 cycles later.
REQ-039 Bench: UART alone holds req for 100 cycles -> gnt stays high all 100 cycles.
REQ-040 Bench: SRAM_ARB_RR_EN defined, UART and M1 both continuously requesting short bursts -> grants alternate 1, 2, 1, 2.
REQ-041 Bench: resetn pulsed low mid-read burst -> gnt=0, rvalid stays 0 for the next 3 cycles, and the FSM is in S_ARB_IDLE.
